// File: rtl/vram_port_arbiter_pkg.sv
// Shared types and constants for the VRAM port A arbiter.
package vram_arb_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PPU,
    GNT_CPU,
    GNT_DMA
  } gnt_t;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic is_cd_grant(gnt_t g);
    return (g == GNT_CPU) || (g == GNT_DMA);
  endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Requester and VRAM port A signal bundle; slave is the arbiter side.
interface vram_arb_if #(
  parameter int ADDR_W = vram_arb_pkg::ADDR_W,
  parameter int DATA_W = vram_arb_pkg::DATA_W
);

  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_ack;
  logic              ppu_rvalid;
  logic [DATA_W-1:0] ppu_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [3:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [3:0]        dma_be;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_wren;
  logic [3:0]        mem_byteena;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  ppu_req, ppu_addr,
    output ppu_ack, ppu_rvalid, ppu_rdata,
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    output dma_ack, dma_rvalid, dma_rdata,
    output mem_wren, mem_byteena, mem_address, mem_data,
    input  mem_q
  );

  modport master (
    output ppu_req, ppu_addr,
    input  ppu_ack, ppu_rvalid, ppu_rdata,
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    input  dma_ack, dma_rvalid, dma_rdata,
    input  mem_wren, mem_byteena, mem_address, mem_data,
    output mem_q
  );

endinterface

// File: rtl/vram_port_arbiter_rr2.sv
// Two-way round-robin picker: winner 0 = CPU, 1 = DMA.
module vram_arb_rr2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       winner
);

  logic rr_ptr_reg;
  logic rr_ptr_next;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    winner      = rr_ptr_reg;
    rr_ptr_next = rr_ptr_reg;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = rr_ptr_reg;
    endcase
    if (advance) begin
      rr_ptr_next = ~winner;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Arbitrates VRAM port A between PPU (fixed priority), CPU and DMA (round-robin),
// with a wait counter that forces a CPU/DMA slot through a PPU stream.
module vram_port_arbiter #(
  parameter int ADDR_W   = vram_arb_pkg::ADDR_W,
  parameter int DATA_W   = vram_arb_pkg::DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic      clock,
  input  logic      reset,
  vram_arb_if.slave bus
);

  import vram_arb_pkg::gnt_t;
  import vram_arb_pkg::req_t;
  import vram_arb_pkg::GNT_NONE;
  import vram_arb_pkg::GNT_PPU;
  import vram_arb_pkg::GNT_CPU;
  import vram_arb_pkg::GNT_DMA;
  import vram_arb_pkg::WAIT_W;
  import vram_arb_pkg::is_cd_grant;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  gnt_t              gnt;
  req_t              cpu_r;
  req_t              dma_r;
  req_t              sel_r;
  logic              cd_any;
  logic              forced;
  logic              rr_winner;
  logic              rr_advance;
  logic [2:0]        rd_grant;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;

  assign cpu_r = '{we: bus.cpu_we, be: bus.cpu_be, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
  assign dma_r = '{we: bus.dma_we, be: bus.dma_be, addr: bus.dma_addr, wdata: bus.dma_wdata};

  assign cd_any = bus.cpu_req | bus.dma_req;
  assign forced = cd_any && (wait_cnt_reg == WAIT_LIMIT);

  vram_arb_rr2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     ({bus.dma_req, bus.cpu_req}),
    .advance (rr_advance),
    .winner  (rr_winner)
  );

  // Grant is held off while reset is asserted so the port stays quiet.
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (forced) begin
        gnt = rr_winner ? GNT_DMA : GNT_CPU;
      end else if (bus.ppu_req) begin
        gnt = GNT_PPU;
      end else if (cd_any) begin
        gnt = rr_winner ? GNT_DMA : GNT_CPU;
      end
    end
  end

  assign rr_advance  = is_cd_grant(gnt);
  assign bus.ppu_ack = (gnt == GNT_PPU);
  assign bus.cpu_ack = (gnt == GNT_CPU);
  assign bus.dma_ack = (gnt == GNT_DMA);

  assign sel_r = (gnt == GNT_DMA) ? dma_r : cpu_r;

  always_comb begin
    bus.mem_wren    = 1'b0;
    bus.mem_byteena = '0;
    bus.mem_address = '0;
    bus.mem_data    = '0;
    case (gnt)
      GNT_PPU: begin
        bus.mem_address = bus.ppu_addr;
      end
      GNT_CPU, GNT_DMA: begin
        bus.mem_address = sel_r.addr;
        bus.mem_data    = sel_r.wdata;
        bus.mem_byteena = sel_r.be;
        bus.mem_wren    = sel_r.we && (sel_r.be != '0);
      end
      default: begin
        bus.mem_wren = 1'b0;
      end
    endcase
  end

  // Index 0 = PPU (always a read), 1 = CPU, 2 = DMA.
  assign rd_grant = {(gnt == GNT_DMA) && !bus.dma_we,
                     (gnt == GNT_CPU) && !bus.cpu_we,
                     (gnt == GNT_PPU)};

  for (genvar gi = 0; gi < 3; gi++) begin : g_ret
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= rd_grant[gi];
        if (rd_grant[gi]) begin
          rdata_reg <= bus.mem_q;
        end
      end
    end
  end

  assign bus.ppu_rvalid = g_ret[0].rvalid_reg;
  assign bus.ppu_rdata  = g_ret[0].rdata_reg;
  assign bus.cpu_rvalid = g_ret[1].rvalid_reg;
  assign bus.cpu_rdata  = g_ret[1].rdata_reg;
  assign bus.dma_rvalid = g_ret[2].rvalid_reg;
  assign bus.dma_rdata  = g_ret[2].rdata_reg;

  // Counts cycles a pending CPU/DMA request has been passed over.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (rr_advance || !cd_any) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg < WAIT_LIMIT) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single read/write port A of the 16K x 32 VRAM bank between three requesters: the PPU fetch unit, the CPU bus bridge and the DMA engine.
- The PPU has fixed priority. CPU and DMA alternate round-robin.
- A wait counter guarantees CPU/DMA a slot while the PPU is streaming.
- The block issues one memory access per clock and returns registered read data one cycle after grant.

Parameters:
- ADDR_W, 14, word address width; matches VRAM depth 16384.
- DATA_W, 32, data width.
- MAX_WAIT, 8, cycles a CPU/DMA request may be blocked by the PPU before it is forced through. Range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ppu_req  in  1  PPU read request (level).
- ppu_addr  in  ADDR_W  PPU word address.
- ppu_ack  out  1  PPU request granted this cycle.
- ppu_rvalid  out  1  ppu_rdata valid.
- ppu_rdata  out  DATA_W  PPU read data.
- cpu_req  in  1  CPU request (level).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_be  in  4  CPU byte enables (write only).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  CPU granted this cycle.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_rdata  out  DATA_W  CPU read data.
- dma_req, dma_we, dma_be, dma_addr, dma_wdata, dma_ack, dma_rvalid, dma_rdata: identical to the cpu_* set, for the DMA engine.
- mem_wren  out  1  VRAM port A write enable.
- mem_byteena  out  4  VRAM port A byte enables.
- mem_address  out  ADDR_W  VRAM port A address.
- mem_data  out  DATA_W  VRAM port A write data.
- mem_q  in  DATA_W  VRAM port A read data (combinational from mem_address).

Behaviour:
- Handshake:
  - A requester holds req, we, be, addr and wdata stable until it sees ack high at a rising edge.
  - The access completes in the ack cycle; req may drop or present a new request the next cycle.
  - The PPU is read-only.
- Arbitration (combinational, each cycle, exactly one grant or none):
  - Forced slot: if wait_cnt == MAX_WAIT and CPU or DMA is requesting, grant the round-robin winner of CPU/DMA, even if ppu_req is high.
  - Otherwise, if ppu_req is high, grant the PPU.
  - Otherwise grant the round-robin winner of CPU/DMA.
  - Round-robin: rr_ptr = 0 favours CPU, 1 favours DMA. On a CPU grant rr_ptr <= 1; on a DMA grant rr_ptr <= 0. If only one of the two requests, it wins regardless of rr_ptr.
- Memory drive:
  - mem_address, mem_data and mem_byteena come from the granted requester, combinationally.
  - mem_wren = grant is CPU/DMA, we = 1, and be != 0.
  - A write with be = 0 is acked and performs no write.
  - With no grant, all mem_* outputs are 0.
- Read return:
  - On a read grant, mem_q is registered into the granted requester's rdata at the rising edge.
  - That requester's rvalid pulses high for exactly the next cycle.
  - rdata holds its last value otherwise.
  - Writes never produce rvalid.
- Wait counter (wait_cnt, 8 bits):
  - Cleared on a CPU/DMA grant, or when neither cpu_req nor dma_req is high.
  - Otherwise increments each cycle and saturates at MAX_WAIT.
  - Consequence: a PPU stream gives CPU/DMA at least 1 slot in every MAX_WAIT+1 cycles.
- Reset (asynchronous): clears every ack, rvalid, rdata, mem_* output, wait_cnt and rr_ptr. A read in flight has its rvalid suppressed.
- Simultaneous events: all three requesting with wait_cnt < MAX_WAIT grants the PPU; CPU and DMA see no ack and wait_cnt increments.
- Same-address hazard: a write granted in cycle N is visible to any read granted in cycle N+1 or later.

Decomposition:
- Package vram_arb_pkg holds:
  - ADDR_W and DATA_W constants.
  - typedef enum logic [1:0] {GNT_NONE, GNT_PPU, GNT_CPU, GNT_DMA} gnt_t.
  - A packed struct req_t {we, be, addr, wdata}.
- One sub-module, vram_arb_rr2: two-requester round-robin picker holding rr_ptr, with inputs req[1:0] and advance, and output winner.
- Counter, grant mux and read-return registers stay in the top.

Test Plan:
1. CPU only:
   - Write addr 0x0010, wdata 0xDEADBEEF, be 0xF: cpu_ack the same cycle, with mem_wren = 1 and mem_byteena = 0xF.
   - Then read 0x0010: cpu_rvalid the next cycle, cpu_rdata = 0xDEADBEEF.
2. Byte enables:
   - Write 0x11223344 to addr 5 with be 0xF, then 0xAABBCCDD with be 0x3; a read returns 0x1122CCDD.
   - A write with be 0x0 is acked, mem_wren stays 0, and a re-read is unchanged.
3. Round-robin: CPU and DMA both hold reads continuously from reset; grants go CPU, DMA, CPU, DMA, with each rvalid one cycle after its ack.
4. Starvation, MAX_WAIT = 8:
   - ppu_req high continuously, CPU read raised at cycle 0.
   - ppu_ack on cycles 0..7; cpu_ack on cycle 8 with ppu_ack low; ppu_ack resumes on cycle 9.
5. Priority: all three requesting with wait_cnt = 0 → ppu_ack only, and wait_cnt = 1 next cycle.
6. Reset mid-read: assert reset asynchronously in the cycle after a cpu_ack read → cpu_rvalid = 0, rdata = 0, rr_ptr = 0, and no mem_* activity while reset is held.
